// File: rtl/paddle_quad_encoder.sv
// Paddle/stick/button to quadrature encoder bridge: tracks a virtual encoder
// position and emits one Gray-code step on {enc_a,enc_b} per tick at most.
module paddle_quad_encoder #(
  parameter int STEP_DIV = 5500,
  parameter int DEADBAND = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       left,
  input  logic       right,
  input  logic [7:0] analog,
  input  logic [7:0] paddle,
  output logic       enc_a,
  output logic       enc_b,
  output logic [7:0] pos,
  output logic       step_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] RESYNC = 2'd2;

  localparam logic [15:0] TICK_LAST = 16'(STEP_DIV - 1);

  logic [15:0]       tickCnt_q, tickCnt_d;
  logic [1:0]        state_q, state_d;
  logic [1:0]        modePrev_q, modePrev_d;
  logic [1:0]        phase_q, phase_d;
  logic [7:0]        pos_q, pos_d;
  logic              step_q, step_d;

  logic              tick;
  logic              modeChange;
  logic              absMode;
  logic [7:0]        target;
  logic signed [8:0] err;
  logic              stepUp;
  logic              stepDown;

  // Forward walks 00->01->11->10; reverse walks the same ring backwards.
  function automatic logic [1:0] phaseAdvance(input logic [1:0] ph, input logic up);
    return up ? {ph[0], ~ph[1]} : {~ph[0], ph[1]};
  endfunction

  assign tick       = (tickCnt_q == TICK_LAST);
  assign modeChange = (mode != modePrev_q);
  assign absMode    = (mode == 2'b01) || (mode == 2'b10);

  always_comb begin
    case (mode)
      2'b01:   target = analog ^ 8'h80;
      2'b10:   target = paddle;
      default: target = pos_q;
    endcase
  end

  assign err = $signed({1'b0, target}) - $signed({1'b0, pos_q});

  // Saturation in absolute modes falls out of the end-stop guards.
  always_comb begin
    stepUp   = 1'b0;
    stepDown = 1'b0;
    if (absMode) begin
      if (int'(err) > DEADBAND && pos_q != 8'hFF) begin
        stepUp = 1'b1;
      end else if (int'(err) < -DEADBAND && pos_q != 8'h00) begin
        stepDown = 1'b1;
      end
    end else begin
      stepUp   = right & ~left;
      stepDown = left & ~right;
    end
  end

  // A mode change wins over everything, including a tick in the same cycle.
  always_comb begin
    tickCnt_d  = tick ? 16'd0 : tickCnt_q + 16'd1;
    state_d    = IDLE;
    modePrev_d = modePrev_q;
    pos_d      = pos_q;
    phase_d    = phase_q;
    step_d     = 1'b0;
    if (modeChange) begin
      state_d    = RESYNC;
      modePrev_d = mode;
      tickCnt_d  = 16'd0;
    end else begin
      case (state_q)
        RESYNC: begin
          tickCnt_d = 16'd0;
          if (absMode) pos_d = target;
        end
        STEP: state_d = IDLE;
        default: begin
          if (tick && (stepUp || stepDown)) begin
            state_d = STEP;
            step_d  = 1'b1;
            pos_d   = stepUp ? pos_q + 8'd1 : pos_q - 8'd1;
            phase_d = phaseAdvance(phase_q, stepUp);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tickCnt_q  <= 16'd0;
      state_q    <= IDLE;
      modePrev_q <= mode;
      phase_q    <= 2'b00;
      pos_q      <= 8'h80;
      step_q     <= 1'b0;
    end else begin
      tickCnt_q  <= tickCnt_d;
      state_q    <= state_d;
      modePrev_q <= modePrev_d;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      step_q     <= step_d;
    end
  end

  assign enc_a  = phase_q[1];
  assign enc_b  = phase_q[0];
  assign pos    = pos_q;
  assign step_o = step_q;

endmodule
